// File: rtl/ff_bank_pkg.sv
// Shared mode encodings and parameter defaults for the multimode flip-flop bank.
// Imported by the per-bit cell and the bank top.
package ff_bank_pkg;

    localparam logic [1:0] MODE_D  = 2'b00;
    localparam logic [1:0] MODE_T  = 2'b01;
    localparam logic [1:0] MODE_JK = 2'b10;
    localparam logic [1:0] MODE_SR = 2'b11;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/ff_cell.sv
// One bit of the bank: next-state and illegal-SR decode for D/T/JK/SR modes.
// Latency: purely combinational, the bank holds the register.
// Backpressure: none, evaluated every cycle.
module ff_cell
    import ff_bank_pkg::*;
(
    input  logic [1:0] mode,
    input  logic       a,
    input  logic       b,
    input  logic       q,
    output logic       q_nxt,
    output logic       illegal
);

    always_comb begin
        q_nxt   = q;
        illegal = 1'b0;
        case (mode)
            MODE_D: q_nxt = a;
            MODE_T: q_nxt = q ^ a;
            MODE_JK: begin
                case ({a, b})
                    2'b01:   q_nxt = 1'b0;
                    2'b10:   q_nxt = 1'b1;
                    2'b11:   q_nxt = ~q;
                    default: q_nxt = q;
                endcase
            end
            default: begin
                // SR: S=R=1 is undefined for a real latch, so the bit holds and is flagged
                case ({a, b})
                    2'b01:   q_nxt = 1'b0;
                    2'b10:   q_nxt = 1'b1;
                    2'b11:   illegal = 1'b1;
                    default: q_nxt = q;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multimode_ff_bank.sv
// Bank of WIDTH multimode flip-flops with parallel load, change pulse, transition counter, sticky SR error.
// Latency: q updates on the edge that samples the inputs; changed/toggles/err reflect that same edge.
// Backpressure: none; en gates updates, ld overrides en and mode.
module multimode_ff_bank
    import ff_bank_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic             changed,
    output logic [CNT_W-1:0] toggles,
    output logic             err
);

    localparam logic [CNT_W+7:0] CNT_MAX = {8'b0, {CNT_W{1'b1}}};

    logic [WIDTH-1:0] cell_nxt;
    logic [WIDTH-1:0] cell_ill;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] diff;
    logic [6:0]       pop;
    logic [CNT_W+7:0] sum;
    logic [CNT_W-1:0] toggles_next;
    logic             err_set;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        ff_cell u_cell (
            .mode    (mode),
            .a       (a[i]),
            .b       (b[i]),
            .q       (q[i]),
            .q_nxt   (cell_nxt[i]),
            .illegal (cell_ill[i])
        );
    end

    always_comb begin
        if (ld) begin
            q_next = ld_val;
        end else if (en) begin
            q_next = cell_nxt;
        end else begin
            q_next = q;
        end
    end

    assign diff = q_next ^ q;

    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + {6'b0, diff[i]};
        end
    end

    // Eight guard bits let a full-width popcount land on a small counter without wrapping
    assign sum          = {8'b0, toggles} + {{(CNT_W + 1){1'b0}}, pop};
    assign toggles_next = (sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum[CNT_W-1:0];

    // Loads never flag; cell_ill is only ever raised in SR mode
    assign err_set = en & ~ld & (|cell_ill);

    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= '0;
            changed <= 1'b0;
            toggles <= '0;
            err     <= 1'b0;
        end else begin
            q       <= q_next;
            changed <= |diff;
            toggles <= toggles_next;
            err     <= err_set | (err & ~err_clr);
        end
    end

    assign q_n = ~q;

endmodule

// File: tb/tb_multimode_ff_bank.sv
// Self-checking bench: directed scenarios plus randomized traffic against a vector-level behavioural model.
module tb_multimode_ff_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       ld = 1'b0;
    logic [7:0] ld_val = '0;
    logic       err_clr = 1'b0;

    logic [7:0]  q, q_n, q_s, q_n_s;
    logic        changed, err, changed_s, err_s;
    logic [15:0] toggles;
    logic [3:0]  toggles_s;

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    logic [7:0] m_q;
    logic       m_chg;
    logic       m_err;
    int         m_cnt;

    always #5 clk = ~clk;

    multimode_ff_bank #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .ld(ld),
        .ld_val(ld_val), .err_clr(err_clr), .q(q), .q_n(q_n), .changed(changed),
        .toggles(toggles), .err(err)
    );

    multimode_ff_bank #(.WIDTH(8), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .ld(ld),
        .ld_val(ld_val), .err_clr(err_clr), .q(q_s), .q_n(q_n_s), .changed(changed_s),
        .toggles(toggles_s), .err(err_s)
    );

    function automatic logic [7:0] model_next(input logic [1:0] md, input logic [7:0] av,
                                              input logic [7:0] bv, input logic [7:0] qv);
        case (md)
            2'd0:    return av;
            2'd1:    return qv ^ av;
            2'd2:    return (av & ~qv) | (~bv & qv);
            default: return (av & ~bv) | (qv & ~(av ^ bv));
        endcase
    endfunction

    function automatic logic [15:0] sat16(input int c);
        return (c > 65535) ? 16'hFFFF : 16'(c);
    endfunction

    function automatic logic [3:0] sat4(input int c);
        return (c > 15) ? 4'hF : 4'(c);
    endfunction

    // Advance model from the inputs held now, clock one edge, settle past it
    task automatic step();
        logic [7:0] nq;
        logic       n_err;
        if (rst) begin
            nq = '0; m_chg = 1'b0; m_cnt = 0; n_err = 1'b0;
        end else begin
            nq = ld ? ld_val : (en ? model_next(mode, a, b, m_q) : m_q);
            m_chg = (nq != m_q);
            m_cnt = m_cnt + $countones(nq ^ m_q);
            n_err = (!ld && en && mode == 2'd3 && (a & b) != 0) ? 1'b1 : (m_err && !err_clr);
        end
        m_q = nq;
        m_err = n_err;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; en = 0; ld = 0; err_clr = 0; a = '0; b = '0; mode = 2'd0;
    endtask

    task automatic test_reset();
        ld = 1; ld_val = 8'hFF; rst = 1; en = 1; err_clr = 0;
        step();
        rst = 0; ld = 0; en = 0;
        n_checks++; if (q !== 8'h00) begin n_errors++; $display("FAIL reset_q: got %h want 00", q); end
        n_checks++; if (q_n !== 8'hFF) begin n_errors++; $display("FAIL reset_q_n: got %h want FF", q_n); end
        n_checks++; if (toggles !== 16'd0) begin n_errors++; $display("FAIL reset_toggles: got %0d want 0", toggles); end
        n_checks++; if (changed !== 1'b0) begin n_errors++; $display("FAIL reset_changed: got %b want 0", changed); end
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b want 0", err); end
    endtask

    task automatic test_t_mode();
        logic [7:0] exp_seq [4];
        exp_seq[0] = 8'hFF; exp_seq[1] = 8'h00; exp_seq[2] = 8'hFF; exp_seq[3] = 8'h00;
        mode = 2'd1; a = 8'hFF; en = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++; if (q !== exp_seq[i]) begin n_errors++; $display("FAIL t_mode_q[%0d]: got %h want %h", i, q, exp_seq[i]); end
            n_checks++; if (changed !== 1'b1) begin n_errors++; $display("FAIL t_mode_changed[%0d]: got %b want 1", i, changed); end
            if (i >= 2) begin
                n_checks++; if (toggles_s !== 4'd15) begin n_errors++; $display("FAIL sat_toggles[%0d]: got %0d want 15", i, toggles_s); end
            end
        end
        n_checks++; if (toggles !== 16'd32) begin n_errors++; $display("FAIL t_mode_toggles: got %0d want 32", toggles); end
        idle_inputs();
        step();
        n_checks++; if (toggles_s !== 4'd15) begin n_errors++; $display("FAIL sat_hold: got %0d want 15", toggles_s); end
    endtask

    task automatic test_jk();
        ld = 1; ld_val = 8'h0F;
        step();
        ld = 0; mode = 2'd2; en = 1; a = 8'hAA; b = 8'h55;
        step();
        n_checks++; if (q !== 8'hAA) begin n_errors++; $display("FAIL jk_set_clear: got %h want AA", q); end
        a = 8'hFF; b = 8'hFF;
        step();
        n_checks++; if (q !== 8'h55) begin n_errors++; $display("FAIL jk_toggle: got %h want 55", q); end
        n_checks++; if (toggles !== sat16(m_cnt)) begin n_errors++; $display("FAIL jk_toggles: got %0d want %0d", toggles, sat16(m_cnt)); end
        idle_inputs();
    endtask

    task automatic test_sr();
        ld = 1; ld_val = 8'h3C;
        step();
        ld = 0; mode = 2'd3; en = 1; a = 8'h01; b = 8'h01;
        step();
        n_checks++; if (q !== 8'h3C) begin n_errors++; $display("FAIL sr_illegal_hold: got %h want 3C", q); end
        n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL sr_err_set: got %b want 1", err); end
        a = 8'h00; b = 8'h00;
        step(); step();
        n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL sr_err_sticky: got %b want 1", err); end
        err_clr = 1;
        step();
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL sr_err_clr: got %b want 0", err); end
        a = 8'h01; b = 8'h01;
        step();
        n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL sr_set_beats_clr: got %b want 1", err); end
        idle_inputs();
    endtask

    task automatic test_ld_priority();
        err_clr = 1;
        step();
        err_clr = 0; ld = 1; ld_val = 8'h5A; en = 0;
        step();
        n_checks++; if (q !== 8'h5A) begin n_errors++; $display("FAIL ld_q: got %h want 5A", q); end
        ld = 0; en = 0;
        step();
        n_checks++; if (q !== 8'h5A) begin n_errors++; $display("FAIL hold_q: got %h want 5A", q); end
        n_checks++; if (changed !== 1'b0) begin n_errors++; $display("FAIL hold_changed: got %b want 0", changed); end
        // Load over an illegal SR pattern must not flag
        ld = 1; ld_val = 8'hA5; en = 1; mode = 2'd3; a = 8'hFF; b = 8'hFF;
        step();
        n_checks++; if (q !== 8'hA5) begin n_errors++; $display("FAIL ld_over_sr_q: got %h want A5", q); end
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL ld_no_err: got %b want 0", err); end
        n_checks++; if (changed !== 1'b1) begin n_errors++; $display("FAIL ld_changed: got %b want 1", changed); end
        idle_inputs();
    endtask

    task automatic test_rst_mid();
        mode = 2'd3; en = 1; a = 8'h80; b = 8'h80;
        step();
        rst = 1; ld = 1; ld_val = 8'h77; err_clr = 0; a = 8'hFF; b = 8'h00;
        step();
        rst = 0; ld = 0;
        n_checks++; if (q !== 8'h00) begin n_errors++; $display("FAIL rst_mid_q: got %h want 00", q); end
        n_checks++; if (changed !== 1'b0) begin n_errors++; $display("FAIL rst_mid_changed: got %b want 0", changed); end
        n_checks++; if (toggles !== 16'd0) begin n_errors++; $display("FAIL rst_mid_toggles: got %0d want 0", toggles); end
        n_checks++; if (toggles_s !== 4'd0) begin n_errors++; $display("FAIL rst_mid_sat: got %0d want 0", toggles_s); end
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL rst_mid_err: got %b want 0", err); end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst     = ($urandom_range(0, 49) == 0);
            ld      = ($urandom_range(0, 7) == 0);
            en      = ($urandom_range(0, 3) != 0);
            err_clr = ($urandom_range(0, 9) == 0);
            mode    = 2'($urandom_range(0, 3));
            a       = 8'($urandom);
            b       = 8'($urandom);
            ld_val  = 8'($urandom);
            step();
            n_checks++; if (q !== m_q) begin n_errors++; $display("FAIL rand_q[%0d]: got %h want %h", i, q, m_q); end
            n_checks++; if (q_n !== ~m_q) begin n_errors++; $display("FAIL rand_q_n[%0d]: got %h want %h", i, q_n, ~m_q); end
            n_checks++; if (changed !== m_chg) begin n_errors++; $display("FAIL rand_changed[%0d]: got %b want %b", i, changed, m_chg); end
            n_checks++; if (toggles !== sat16(m_cnt)) begin n_errors++; $display("FAIL rand_toggles[%0d]: got %0d want %0d", i, toggles, sat16(m_cnt)); end
            n_checks++; if (toggles_s !== sat4(m_cnt)) begin n_errors++; $display("FAIL rand_sat[%0d]: got %0d want %0d", i, toggles_s, sat4(m_cnt)); end
            n_checks++; if (err !== m_err) begin n_errors++; $display("FAIL rand_err[%0d]: got %b want %b", i, err, m_err); end
            n_checks++; if (q_s !== m_q || err_s !== m_err || changed_s !== m_chg || q_n_s !== ~m_q) begin
                n_errors++; $display("FAIL rand_sat_inst[%0d]: got q=%h err=%b chg=%b want q=%h err=%b chg=%b", i, q_s, err_s, changed_s, m_q, m_err, m_chg);
            end
        end
        idle_inputs();
    endtask

    initial begin
        m_q = '0; m_chg = 1'b0; m_err = 1'b0; m_cnt = 0;
        #2;
        test_reset();
        test_t_mode();
        test_jk();
        test_sr();
        test_ld_priority();
        test_rst_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
